// File: rtl/ps2_key_counter.sv
// PS/2 keyboard front end: frame receiver, make/break/typematic decoder
// and an 8-bit count of distinct key presses for the BCD display path.
module ps2_key_counter #(
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT     = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] o_key,
    output logic       o_pressed,
    output logic [7:0] o_count,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, HELD, BREAK} key_state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   data_s;
    logic                   frame_ok;
    logic [3:0]             bit_cnt;
    logic [9:0]             shift;
    logic [TW-1:0]          idle_cnt;
    key_state_t             state;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // After ten shifts: shift[0] is the start bit, [8:1] the data, [9] the parity.
    assign frame_ok = ~shift[0] & (^shift[9:1]) & data_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= 4'd0;
            shift    <= 10'd0;
            idle_cnt <= '0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
            o_data   <= 8'd0;
        end else begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    o_valid <= frame_ok;
                    o_err   <= ~frame_ok;
                    if (frame_ok) begin
                        o_data <= shift[8:1];
                    end
                end else begin
                    shift   <= {data_s, shift[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                // A stalled partial frame is dropped silently.
                if (idle_cnt == TW'(TIMEOUT - 1)) begin
                    bit_cnt  <= 4'd0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            o_key     <= 8'd0;
            o_pressed <= 1'b0;
            o_count   <= 8'd0;
        end else if (o_valid && o_data != 8'hE0) begin
            case (state)
                IDLE: begin
                    if (o_data == 8'hF0) begin
                        state <= BREAK;
                    end else begin
                        o_key     <= o_data;
                        o_pressed <= 1'b1;
                        o_count   <= o_count + 8'd1;
                        state     <= HELD;
                    end
                end
                HELD: begin
                    if (o_data == 8'hF0) begin
                        state <= BREAK;
                    end else if (o_data != o_key) begin
                        o_key   <= o_data;
                        o_count <= o_count + 8'd1;
                    end
                end
                BREAK: begin
                    o_pressed <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
